// File: rtl/pll_rst_ctrl.sv
// -----------------------------------------------------------------------------
// pll_rst_ctrl
//
// Purpose
//   Sequences the clock-generation PLL from sys_clk. The PLL is held in reset
//   for a fixed pulse. The block then waits for pll_locked and requires lock to
//   stay high for a qualifying window before clk_ready is raised. Downstream
//   users of the PLL clocks gate themselves on clk_ready. A loss of lock, or a
//   soft restart request, re-runs the whole sequence. Lock losses seen while
//   READY are counted.
//
// Optional feature (compile-time macro)
//   PLL_LOCK_TIMEOUT_EN
//     Defined:   WAIT_LOCK is bounded to TIMEOUT_CYC cycles. On expiry the
//                block raises the sticky timeout_err and retries the reset
//                pulse, forever.
//     Undefined: WAIT_LOCK waits indefinitely and timeout_err is tied low.
//
// Parameters
//   RST_HOLD_CYC  sys_clk cycles pll_rst is held high per reset pulse (>=1)
//   STABLE_CYC    consecutive synchronised-lock cycles required before READY
//   TIMEOUT_CYC   WAIT_LOCK bound, used only with PLL_LOCK_TIMEOUT_EN
//   CNT_W         phase counter width; must hold the largest of the three
//
// Ports
//   sys_clk       in   system clock, sole clock of this block
//   sys_rst_n     in   asynchronous active-low reset
//   pll_locked    in   PLL lock, asynchronous to sys_clk (2-flop synchronised)
//   soft_restart  in   one-cycle request to re-run the reset sequence
//   pll_rst       out  active-high reset to the PLL IP
//   clk_ready     out  PLL outputs qualified usable
//   lock_lost     out  one-cycle pulse when synchronised lock drops in READY
//   relock_cnt    out  lock-loss count, saturating at 255
//   timeout_err   out  sticky WAIT_LOCK timeout flag
// -----------------------------------------------------------------------------
module pll_rst_ctrl #(
   parameter int RST_HOLD_CYC = 10,
   parameter int STABLE_CYC   = 1000,
   parameter int TIMEOUT_CYC  = 50000,
   parameter int CNT_W        = 16
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       pll_locked,
   input  logic       soft_restart,
   output logic       pll_rst,
   output logic       clk_ready,
   output logic       lock_lost,
   output logic [7:0] relock_cnt,
   output logic       timeout_err
);

   typedef enum logic [1:0] {
      RESET_PLL = 2'd0,
      WAIT_LOCK = 2'd1,
      STABLE    = 2'd2,
      READY     = 2'd3
   } state_t;

   // Terminal counts of each timed phase.
   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);

   // Largest terminal count of any phase. The counter never advances beyond
   // it, so a mis-sized CNT_W cannot let the counter wrap and re-hit a
   // terminal value.
   localparam int CNT_NEED_A = (RST_HOLD_CYC > STABLE_CYC) ? RST_HOLD_CYC : STABLE_CYC;
   localparam int CNT_NEED   = (CNT_NEED_A > TIMEOUT_CYC) ? CNT_NEED_A : TIMEOUT_CYC;
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_NEED - 1);

`ifdef PLL_LOCK_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
`endif

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             lock_meta_q;
   logic             lock_s;
   logic             lock_lost_d;
   logic [7:0]       relock_cnt_d;
   logic             timeout_d;

   function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_TOP) ? v : v + CNT_W'(1);
   endfunction

   // --------------------------------------------------------------------------
   // pll_locked synchroniser. lock_s lags pll_locked by two sys_clk edges, and
   // every decision below uses lock_s only.
   // --------------------------------------------------------------------------
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         lock_meta_q <= 1'b0;
         lock_s      <= 1'b0;
      end else begin
         lock_meta_q <= pll_locked;
         lock_s      <= lock_meta_q;
      end
   end

   // --------------------------------------------------------------------------
   // State and counter registers, plus outputs.
   // The outputs are decoded from the next state, so each output changes on
   // the same edge as the state it belongs to, and still leaves a flop.
   // --------------------------------------------------------------------------
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= RESET_PLL;
         cnt_q      <= '0;
         pll_rst    <= 1'b1;
         clk_ready  <= 1'b0;
         lock_lost  <= 1'b0;
         relock_cnt <= 8'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pll_rst    <= (state_d == RESET_PLL);
         clk_ready  <= (state_d == READY);
         lock_lost  <= lock_lost_d;
         relock_cnt <= relock_cnt_d;
      end
   end

`ifdef PLL_LOCK_TIMEOUT_EN
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= timeout_d;
      end
   end
`else
   assign timeout_err = 1'b0;
`endif

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      lock_lost_d  = 1'b0;
      relock_cnt_d = relock_cnt;
      timeout_d    = timeout_err;

      case (state_q)
         // Fixed-length PLL reset pulse. A restart request here would only
         // restart a pulse that is already running, so it is ignored.
         RESET_PLL: begin
            if (cnt_q == RST_LAST) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc(cnt_q);
            end
         end

         WAIT_LOCK: begin
            if (soft_restart) begin
               state_d = RESET_PLL;
               cnt_d   = '0;
            end else if (lock_s) begin
               // Lock arriving on the last allowed cycle beats the timeout.
               state_d = STABLE;
               cnt_d   = '0;
            end
`ifdef PLL_LOCK_TIMEOUT_EN
            else if (cnt_q == TIMEOUT_LAST) begin
               timeout_d = 1'b1;
               state_d   = RESET_PLL;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_inc(cnt_q);
            end
`endif
         end

         // The qualifying window must be unbroken. Any dropout sends the
         // sequence back to WAIT_LOCK without being treated as a lock loss.
         STABLE: begin
            if (soft_restart) begin
               state_d = RESET_PLL;
               cnt_d   = '0;
            end else if (!lock_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = READY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc(cnt_q);
            end
         end

         // A lock loss takes priority over a coincident soft restart. Both
         // lead to RESET_PLL, but only the loss pulses and is counted.
         READY: begin
            if (!lock_s) begin
               lock_lost_d = 1'b1;
               if (relock_cnt != 8'hFF) begin
                  relock_cnt_d = relock_cnt + 8'd1;
               end
               state_d = RESET_PLL;
               cnt_d   = '0;
            end else if (soft_restart) begin
               state_d = RESET_PLL;
               cnt_d   = '0;
            end
         end

         default: begin
            state_d = RESET_PLL;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pll_rst_ctrl
//
// Directed test of pll_rst_ctrl with RST_HOLD_CYC=4, STABLE_CYC=8 and
// TIMEOUT_CYC=32.
//
// Every change of the output tuple is an event. When the driver issues
// stimulus, it pushes each expected event onto exp_q as a
// {cycle, outputs} word. A monitor samples the outputs on every falling
// clock edge. Whenever the tuple changes, the monitor pops the next expected
// word and compares both the values and the rising-edge number at which the
// change occurred.
// -----------------------------------------------------------------------------
module tb_pll_rst_ctrl;

   localparam int RST_HOLD_CYC = 4;
   localparam int STABLE_CYC   = 8;
   localparam int TIMEOUT_CYC  = 32;
   localparam int CNT_W        = 16;
   localparam int W            = 44;   // {cycle[31:0], obs[11:0]}

   logic       sys_clk = 1'b0;
   logic       sys_rst_n;
   logic       pll_locked;
   logic       soft_restart;
   logic       pll_rst;
   logic       clk_ready;
   logic       lock_lost;
   logic [7:0] relock_cnt;
   logic       timeout_err;

   int         cyc      = 0;
   int         n_checks = 0;
   int         n_pass   = 0;
   logic [W-1:0] exp_q[$];

   // Expected output model, updated by the driver before each push.
   logic       m_rst;
   logic       m_rdy;
   logic       m_lost;
   logic       m_tmo;
   logic [7:0] m_cnt;
   logic [11:0] prev_obs = 'x;

   pll_rst_ctrl #(
      .RST_HOLD_CYC (RST_HOLD_CYC),
      .STABLE_CYC   (STABLE_CYC),
      .TIMEOUT_CYC  (TIMEOUT_CYC),
      .CNT_W        (CNT_W)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .pll_locked   (pll_locked),
      .soft_restart (soft_restart),
      .pll_rst      (pll_rst),
      .clk_ready    (clk_ready),
      .lock_lost    (lock_lost),
      .relock_cnt   (relock_cnt),
      .timeout_err  (timeout_err)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   function automatic void push(input int at);
      logic [31:0] at32;
      at32 = at;
      exp_q.push_back({at32, m_rst, m_rdy, m_lost, m_tmo, m_cnt});
   endfunction

   always @(negedge sys_clk) begin : monitor
      logic [11:0]  obs;
      logic [W-1:0] e;
      obs = {pll_rst, clk_ready, lock_lost, timeout_err, relock_cnt};
      if (obs !== prev_obs) begin
         prev_obs = obs;
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_change at cyc=%0d got obs=%03h, required no change",
                     cyc, obs);
         end else begin
            e = exp_q.pop_front();
            if (e[11:0] === obs && e[43:12] == 32'(cyc)) begin
               n_pass++;
            end else begin
               $display("FAIL output_event got cyc=%0d rst=%b rdy=%b lost=%b tmo=%b cnt=%0d, required cyc=%0d rst=%b rdy=%b lost=%b tmo=%b cnt=%0d",
                        cyc, obs[11], obs[10], obs[9], obs[8], obs[7:0],
                        e[43:12], e[11], e[10], e[9], e[8], e[7:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) step();
   endtask

   // Starting in READY with lock stable: drop pll_locked, optionally raise
   // soft_restart on the same edge that lock_s falls, then relock after the
   // reset pulse. Returns in READY, 20 cycles after the call.
   task automatic lose_lock(input bit with_soft);
      int c;
      c = cyc;
      pll_locked = 1'b0;
      m_rdy = 1'b0; m_lost = 1'b1; m_rst = 1'b1;
      if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
      push(c + 3);                    // 2 sync edges + transition edge
      m_lost = 1'b0;
      push(c + 4);
      m_rst = 1'b0;
      push(c + 7);                    // 4-cycle reset pulse
      wait_cyc(2);
      if (with_soft) soft_restart = 1'b1;
      step();
      soft_restart = 1'b0;
      wait_cyc(4);                    // now at c+7, WAIT_LOCK
      pll_locked = 1'b1;
      m_rdy = 1'b1;
      push(c + 18);                   // 11 edges after lock returns
      wait_cyc(13);
   endtask

   // ---------------- stimulus ----------------
   initial begin : driver
      int c;
      int g;
      int r;

      // Reset values
      sys_rst_n = 1'b0; pll_locked = 1'b0; soft_restart = 1'b0;
      m_rst = 1'b1; m_rdy = 1'b0; m_lost = 1'b0; m_tmo = 1'b0; m_cnt = 8'd0;
      push(1);
      wait_cyc(3);

      // 1. Release reset: pll_rst for exactly 4 cycles. Lock arrives 10 cycles
      //    after pll_rst falls, and clk_ready follows 11 edges later.
      c = cyc;
      sys_rst_n = 1'b1;
      m_rst = 1'b0;
      push(c + 4);
      wait_cyc(14);
      pll_locked = 1'b1;
      m_rdy = 1'b1;
      push(cyc + 11);
      wait_cyc(14);

      // 4a. Soft restart in READY: no pulse, no count. A second request issued
      //     during the reset pulse must not stretch it.
      c = cyc;
      soft_restart = 1'b1;
      pll_locked = 1'b0;
      m_rdy = 1'b0; m_rst = 1'b1;
      push(c + 1);
      step();
      soft_restart = 1'b0;
      step();
      soft_restart = 1'b1;
      step();
      soft_restart = 1'b0;
      m_rst = 1'b0;
      push(c + 5);
      wait_cyc(2);

      // 2. Lock glitch during the window: 5 high, 1 low, then high again.
      //    clk_ready waits for 11 edges after the second rise.
      g = cyc;
      pll_locked = 1'b1;
      wait_cyc(5);
      pll_locked = 1'b0;
      step();
      pll_locked = 1'b1;
      m_rdy = 1'b1;
      push(g + 17);
      wait_cyc(14);

      // 3. Single lock loss (count 1), then 4b: loss with coincident soft
      //    restart (count 2), then enough losses to saturate at 255.
      lose_lock(1'b0);
      lose_lock(1'b1);
      for (int i = 0; i < 300; i++) lose_lock(1'b0);

      // 6. Async reset in READY, then in STABLE.
      c = cyc;
      sys_rst_n = 1'b0;
      pll_locked = 1'b0;
      m_rst = 1'b1; m_rdy = 1'b0; m_lost = 1'b0; m_tmo = 1'b0; m_cnt = 8'd0;
      push(c);
      wait_cyc(2);
      r = cyc;
      sys_rst_n = 1'b1;
      m_rst = 1'b0;
      push(r + 4);
      wait_cyc(4);
      pll_locked = 1'b1;
      wait_cyc(5);                    // STABLE, window part-way through
      sys_rst_n = 1'b0;
      m_rst = 1'b1;
      push(cyc);
      wait_cyc(2);
      r = cyc;
      sys_rst_n = 1'b1;
      m_rst = 1'b0;
      push(r + 4);
      m_rdy = 1'b1;
      push(r + 13);                   // 4 reset + 1 wait + 8 window
      wait_cyc(16);

      // 5. Lock lost and never returns.
      c = cyc;
      pll_locked = 1'b0;
      m_rdy = 1'b0; m_lost = 1'b1; m_rst = 1'b1; m_cnt = 8'd1;
      push(c + 3);
      m_lost = 1'b0;
      push(c + 4);
      m_rst = 1'b0;
      push(c + 7);
`ifdef PLL_LOCK_TIMEOUT_EN
      for (int k = 0; k < 3; k++) begin
         m_rst = 1'b1; m_tmo = 1'b1;
         push(c + 39 + 36 * k);       // 32 cycles in WAIT_LOCK
         m_rst = 1'b0;
         push(c + 43 + 36 * k);
      end
`endif
      wait_cyc(120);

      @(negedge sys_clk);
      #1;
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL pending_events got %0d left, required 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
